async_fifo_source: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 30 +++
 rtl/async_fifo_ptr_sync.sv | 32 +++
 rtl/async_fifo_source.sv | 174 +++++++++++++++++
 tb/tb_async_fifo_source.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the split asynchronous FIFO (source and sink halves).
// Gray/binary converters work on a PTR_MAX_W-bit vector. A narrower pointer
// is zero-extended on the way in and cast back down on the way out. The zero
// upper bits do not disturb the result in either direction.
package async_fifo_pkg;

  localparam int PTR_MAX_W       = 16;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int HOLD_CNT_W      = 3;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } fifo_state_e;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// Generic N-stage, W-bit synchronizer for gray pointers crossing into this
// clock domain. It is a plain shift chain with nothing between the stages,
// and the sink half reuses it as well.
module async_fifo_ptr_sync #(
  parameter int N = 2,
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [N];

  // Shift the asynchronous pointer through N flops; clear them all on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < N; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/async_fifo_source.sv
// Write-side half of a split asynchronous FIFO, entirely in clk_w.
// Owns the storage, the write pointer and the read-pointer synchronizer. It
// exports storage and the gray write pointer as quasi-static buses to the sink.
// Optional feature macro: ASYNC_FIFO_SOURCE_OCC_EN (adds occ_w occupancy port).
//
// state | meaning
// HOLD  | after reset; ready_w held low while the rd pointer synchronizer flushes
// RUN   | normal operation; ready_w = not full
module async_fifo_source
  import async_fifo_pkg::*;
#(
  parameter  int DEPTH_LG_2  = 2,
  parameter  int WIDTH       = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int DEPTH       = 2 ** DEPTH_LG_2,
  localparam int PW          = DEPTH_LG_2 + 1
) (
  input  logic                   clk_w,
  input  logic                   reset_w,
  input  logic                   valid_w,
  output logic                   ready_w,
  input  logic [WIDTH-1:0]       data_w,
  input  logic [PW-1:0]          rd_ptr_gray_i,
  output logic [PW-1:0]          wr_ptr_gray_o,
  output logic [DEPTH*WIDTH-1:0] mem_o
`ifdef ASYNC_FIFO_SOURCE_OCC_EN
  ,
  output logic [PW-1:0]          occ_w
`endif
);

  // Full when the gray pointers differ exactly in their top two bits.
  // With PW=1 this reduces to a single-bit inequality.
  localparam logic [PW-1:0] PTR_TOP   = PW'(1) << (PW - 1);
  localparam logic [PW-1:0] FULL_MASK = PTR_TOP | (PTR_TOP >> 1);

  fifo_state_e           r_state;
  fifo_state_e           w_state_nxt;
  logic [HOLD_CNT_W-1:0] r_cnt;
  logic [HOLD_CNT_W-1:0] w_cnt_nxt;

  logic [PW-1:0]    r_wr_bin;
  logic [PW-1:0]    r_wr_gray;
  logic [PW-1:0]    w_wr_bin_nxt;
  logic [PW-1:0]    w_wr_gray_nxt;
  logic [PW-1:0]    w_rd_gray;
  logic             r_ready;
  logic             w_fire;
  logic             w_full_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  async_fifo_ptr_sync #(
    .N (SYNC_STAGES),
    .W (PW)
  ) u_rd_sync (
    .i_clk (clk_w),
    .i_rst (reset_w),
    .i_d   (rd_ptr_gray_i),
    .o_q   (w_rd_gray)
  );

  assign w_fire        = valid_w & r_ready;
  assign w_wr_bin_nxt  = w_fire ? (r_wr_bin + PW'(1)) : r_wr_bin;
  assign w_wr_gray_nxt = PW'(bin2gray(PTR_MAX_W'(w_wr_bin_nxt)));
  assign w_full_nxt    = ((w_wr_gray_nxt ^ w_rd_gray) == FULL_MASK);

  // FSM state and hold counter registers.
  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      r_state <= HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: leave HOLD once the counter has covered the synchronizer depth.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      HOLD: begin
        w_cnt_nxt = r_cnt + HOLD_CNT_W'(1);
        if (r_cnt == HOLD_CNT_W'(SYNC_STAGES)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = HOLD;
      end
    endcase
  end

  // Binary and gray write pointers advance together on every accepted enqueue.
  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
    end else begin
      r_wr_bin  <= w_wr_bin_nxt;
      r_wr_gray <= w_wr_gray_nxt;
    end
  end

  // ready_w is a flop fed from the post-write pointer and the synchronized rd
  // pointer. It drops on the same edge that fills the last slot, and it rises
  // one edge after a freed slot reaches the synchronizer output.
  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == RUN) && !w_full_nxt;
    end
  end

  generate
    if (DEPTH_LG_2 == 0) begin : g_mailbox
      // Single-entry storage; the payload lands with the pointer update.
      always_ff @(posedge clk_w) begin
        if (w_fire) begin
          r_mem[0] <= data_w;
        end
      end
    end else begin : g_ring
      // Ring storage indexed by the low pointer bits; lands with the pointer update.
      always_ff @(posedge clk_w) begin
        if (w_fire) begin
          r_mem[r_wr_bin[DEPTH_LG_2-1:0]] <= data_w;
        end
      end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign mem_o[gi*WIDTH +: WIDTH] = r_mem[gi];
    end
  endgenerate

  assign ready_w       = r_ready;
  assign wr_ptr_gray_o = r_wr_gray;

`ifdef ASYNC_FIFO_SOURCE_OCC_EN
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] r_occ;

  assign w_rd_bin = PW'(gray2bin(PTR_MAX_W'(w_rd_gray)));

  // Occupancy counts a write on the edge that stores it. The stale synchronized
  // rd pointer can only inflate it, so it never under-reports.
  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      r_occ <= '0;
    end else if (r_state == RUN) begin
      r_occ <= w_wr_bin_nxt - w_rd_bin;
    end else begin
      r_occ <= '0;
    end
  end

  assign occ_w = r_occ;
`endif

  // The sink half must leave reset with this one, so its pointer reads zero
  // once the synchronizer has flushed.
  a_sink_reset_together : assert property (@(posedge clk_w) disable iff (reset_w)
    ((r_state == HOLD) && (w_state_nxt == RUN)) |-> (w_rd_gray == '0));

  a_sync_stages_range : assert property (@(posedge clk_w)
    (SYNC_STAGES >= SYNC_STAGES_MIN) && (SYNC_STAGES <= SYNC_STAGES_MAX));

endmodule

// File: tb/tb_async_fifo_source.sv
// Bench for async_fifo_source: a 4-entry instance (32-bit) and a mailbox
// instance (DEPTH_LG_2=0, 8-bit). The bench plays the sink. It pushes each
// accepted payload to a queue, then pops and compares it against mem_o before
// advancing rd_ptr_gray_i.
module tb_async_fifo_source;

  logic         clk_w = 1'b0;
  logic         reset_w = 1'b1;
  logic         valid_w = 1'b0;
  logic         ready_w;
  logic [31:0]  data_w = '0;
  logic [2:0]   rd_ptr_gray_i = '0;
  logic [2:0]   wr_ptr_gray_o;
  logic [127:0] mem_o;

  logic         valid1 = 1'b0;
  logic         ready1;
  logic [7:0]   data1 = '0;
  logic [0:0]   rd1 = '0;
  logic [0:0]   wr1;
  logic [7:0]   mem1;

`ifdef ASYNC_FIFO_SOURCE_OCC_EN
  logic [2:0]   occ_w;
  logic [0:0]   occ1;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [7:0]  sb1_q[$];
  int unsigned m_wr = 0;
  int unsigned m_rd = 0;

  always #5 clk_w = ~clk_w;

  async_fifo_source #(.DEPTH_LG_2(2), .WIDTH(32), .SYNC_STAGES(2)) u_dut (
    .clk_w         (clk_w),
    .reset_w       (reset_w),
    .valid_w       (valid_w),
    .ready_w       (ready_w),
    .data_w        (data_w),
    .rd_ptr_gray_i (rd_ptr_gray_i),
    .wr_ptr_gray_o (wr_ptr_gray_o),
    .mem_o         (mem_o)
`ifdef ASYNC_FIFO_SOURCE_OCC_EN
    ,
    .occ_w         (occ_w)
`endif
  );

  async_fifo_source #(.DEPTH_LG_2(0), .WIDTH(8), .SYNC_STAGES(2)) u_mbox (
    .clk_w         (clk_w),
    .reset_w       (reset_w),
    .valid_w       (valid1),
    .ready_w       (ready1),
    .data_w        (data1),
    .rd_ptr_gray_i (rd1),
    .wr_ptr_gray_o (wr1),
    .mem_o         (mem1)
`ifdef ASYNC_FIFO_SOURCE_OCC_EN
    ,
    .occ_w         (occ1)
`endif
  );

  function automatic logic [2:0] gray3(input int unsigned b);
    logic [2:0] x;
    x = 3'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic step();
    @(posedge clk_w);
    #1;
  endtask

  task automatic do_reset();
    reset_w = 1'b1;
    valid_w = 1'b0;
    valid1 = 1'b0;
    data_w = '0;
    data1 = '0;
    rd_ptr_gray_i = '0;
    rd1 = '0;
    sb_q.delete();
    sb1_q.delete();
    m_wr = 0;
    m_rd = 0;
    step();
    step();
    reset_w = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    reset_w = 1'b1;
    valid_w = 1'b1;
    step();
    step();
    n_vec++; if (ready_w !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b want 0", ready_w); end
    n_vec++; if (wr_ptr_gray_o !== 3'b000) begin n_err++; $display("FAIL reset_wr_gray: got %03b want 000", wr_ptr_gray_o); end
    n_vec++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL reset_mbox_ready: got %0b want 0", ready1); end
    n_vec++; if (wr1 !== 1'b0) begin n_err++; $display("FAIL reset_mbox_wr_gray: got %0b want 0", wr1); end
`ifdef ASYNC_FIFO_SOURCE_OCC_EN
    n_vec++; if (occ_w !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occ_w); end
`endif
  endtask

  task automatic test_hold();
    logic exp_rdy;
    valid_w = 1'b1;
    data_w = 32'h11;
    reset_w = 1'b0;
    n_vec++; if (ready_w !== 1'b0) begin n_err++; $display("FAIL hold_ready_e0: got %0b want 0", ready_w); end
    for (int i = 0; i < 3; i++) begin
      step();
      exp_rdy = (i == 2);
      n_vec++; if (ready_w !== exp_rdy) begin n_err++; $display("FAIL hold_ready_e%0d: got %0b want %0b", i + 1, ready_w, exp_rdy); end
      n_vec++; if (wr_ptr_gray_o !== 3'b000) begin n_err++; $display("FAIL hold_ignores_valid_e%0d: got %03b want 000", i + 1, wr_ptr_gray_o); end
    end
    step();
    m_wr++;
    sb_q.push_back(32'h11);
    valid_w = 1'b0;
    n_vec++; if (wr_ptr_gray_o !== 3'b001) begin n_err++; $display("FAIL first_fire_gray: got %03b want 001", wr_ptr_gray_o); end
    n_vec++; if (mem_o[31:0] !== 32'h11) begin n_err++; $display("FAIL first_fire_mem0: got %08h want 00000011", mem_o[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_g [4];
    logic [31:0] d;
    exp_g[0] = 3'b001;
    exp_g[1] = 3'b011;
    exp_g[2] = 3'b010;
    exp_g[3] = 3'b110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = 32'hA0 + 32'(i);
      valid_w = 1'b1;
      data_w = d;
      n_vec++; if (ready_w !== 1'b1) begin n_err++; $display("FAIL b2b_ready_w%0d: got %0b want 1", i, ready_w); end
      step();
      m_wr++;
      sb_q.push_back(d);
      n_vec++; if (wr_ptr_gray_o !== exp_g[i]) begin n_err++; $display("FAIL b2b_gray_w%0d: got %03b want %03b", i, wr_ptr_gray_o, exp_g[i]); end
    end
    n_vec++; if (ready_w !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %0b want 0", ready_w); end
    data_w = 32'hA4;
    step();
    valid_w = 1'b0;
    n_vec++; if (wr_ptr_gray_o !== 3'b110) begin n_err++; $display("FAIL b2b_full_ptr_held: got %03b want 110", wr_ptr_gray_o); end
    n_vec++; if (ready_w !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready_held: got %0b want 0", ready_w); end
    n_vec++; if (mem_o[31:0] !== 32'hA0) begin n_err++; $display("FAIL b2b_no_overrun: got %08h want 000000a0", mem_o[31:0]); end
    n_vec++; if (mem_o[127:96] !== 32'hA3) begin n_err++; $display("FAIL b2b_mem3: got %08h want 000000a3", mem_o[127:96]); end
  endtask

  task automatic test_drain_latency();
    logic [31:0] exp_d;
    int unsigned idx;
    logic exp_rdy;
    idx = m_rd % 4;
    exp_d = sb_q.pop_front();
    n_vec++; if (mem_o[idx*32 +: 32] !== exp_d) begin n_err++; $display("FAIL drain_data: got %08h want %08h", mem_o[idx*32 +: 32], exp_d); end
    m_rd++;
    rd_ptr_gray_i = gray3(m_rd);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_rdy = (i == 2);
      n_vec++; if (ready_w !== exp_rdy) begin n_err++; $display("FAIL drain_ready_e%0d: got %0b want %0b", i + 1, ready_w, exp_rdy); end
    end
    valid_w = 1'b1;
    data_w = 32'hB0;
    step();
    valid_w = 1'b0;
    m_wr++;
    sb_q.push_back(32'hB0);
    n_vec++; if (wr_ptr_gray_o !== gray3(m_wr)) begin n_err++; $display("FAIL drain_next_gray: got %03b want %03b", wr_ptr_gray_o, gray3(m_wr)); end
    n_vec++; if (mem_o[31:0] !== 32'hB0) begin n_err++; $display("FAIL drain_next_idx0: got %08h want 000000b0", mem_o[31:0]); end
    n_vec++; if (ready_w !== 1'b0) begin n_err++; $display("FAIL drain_refull: got %0b want 0", ready_w); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d;
    logic [31:0] d;
    logic [2:0]  prev;
    logic        r;
    logic        fired;
    int          k_fire;
    int unsigned idx;
    for (int it = 0; it < 16; it++) begin
      idx = m_rd % 4;
      exp_d = sb_q.pop_front();
      n_vec++; if (mem_o[idx*32 +: 32] !== exp_d) begin n_err++; $display("FAIL wrap_data_%0d: got %08h want %08h", it, mem_o[idx*32 +: 32], exp_d); end
      m_rd++;
      rd_ptr_gray_i = gray3(m_rd);
      d = 32'hC0 + 32'(it);
      valid_w = 1'b1;
      data_w = d;
      fired = 1'b0;
      k_fire = -1;
      prev = wr_ptr_gray_o;
      for (int k = 0; k < 8 && !fired; k++) begin
        r = ready_w;
        prev = wr_ptr_gray_o;
        step();
        if (r) begin
          fired = 1'b1;
          k_fire = k;
        end
      end
      valid_w = 1'b0;
      n_vec++; if (fired !== 1'b1) begin n_err++; $display("FAIL wrap_false_full_%0d: got no accept want accept within 8 cycles", it); end
      if (fired) begin
        m_wr++;
        sb_q.push_back(d);
        n_vec++; if (k_fire != 3) begin n_err++; $display("FAIL wrap_latency_%0d: got edge %0d want edge 3", it, k_fire); end
        n_vec++; if (wr_ptr_gray_o !== gray3(m_wr)) begin n_err++; $display("FAIL wrap_gray_%0d: got %03b want %03b", it, wr_ptr_gray_o, gray3(m_wr)); end
        n_vec++; if ($countones(prev ^ wr_ptr_gray_o) != 1) begin n_err++; $display("FAIL wrap_onebit_%0d: got %03b->%03b want one bit change", it, prev, wr_ptr_gray_o); end
      end
    end
  endtask

  task automatic test_mailbox();
    logic [7:0] exp_d;
    logic exp_rdy;
    do_reset();
    valid1 = 1'b1;
    data1 = 8'h55;
    n_vec++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL mbox_ready_empty: got %0b want 1", ready1); end
    step();
    valid1 = 1'b0;
    sb1_q.push_back(8'h55);
    n_vec++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL mbox_ready_full: got %0b want 0", ready1); end
    n_vec++; if (wr1 !== 1'b1) begin n_err++; $display("FAIL mbox_wr_gray: got %0b want 1", wr1); end
    exp_d = sb1_q.pop_front();
    n_vec++; if (mem1 !== exp_d) begin n_err++; $display("FAIL mbox_data: got %02h want %02h", mem1, exp_d); end
    rd1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_rdy = (i == 2);
      n_vec++; if (ready1 !== exp_rdy) begin n_err++; $display("FAIL mbox_drain_e%0d: got %0b want %0b", i + 1, ready1, exp_rdy); end
    end
  endtask

  task automatic test_reset_midstream();
    logic exp_rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid_w = 1'b1;
      data_w = 32'hD0 + 32'(i);
      step();
      m_wr++;
      sb_q.push_back(data_w);
    end
    valid_w = 1'b0;
    n_vec++; if (wr_ptr_gray_o !== gray3(m_wr)) begin n_err++; $display("FAIL mid_pre_gray: got %03b want %03b", wr_ptr_gray_o, gray3(m_wr)); end
`ifdef ASYNC_FIFO_SOURCE_OCC_EN
    step();
    n_vec++; if (occ_w !== 3'd3) begin n_err++; $display("FAIL mid_pre_occ: got %0d want 3", occ_w); end
`endif
    #2;
    reset_w = 1'b1;
    #1;
    n_vec++; if (ready_w !== 1'b0) begin n_err++; $display("FAIL mid_async_ready: got %0b want 0", ready_w); end
    n_vec++; if (wr_ptr_gray_o !== 3'b000) begin n_err++; $display("FAIL mid_async_gray: got %03b want 000", wr_ptr_gray_o); end
`ifdef ASYNC_FIFO_SOURCE_OCC_EN
    n_vec++; if (occ_w !== 3'd0) begin n_err++; $display("FAIL mid_async_occ: got %0d want 0", occ_w); end
`endif
    sb_q.delete();
    m_wr = 0;
    m_rd = 0;
    step();
    step();
    reset_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_rdy = (i == 2);
      n_vec++; if (ready_w !== exp_rdy) begin n_err++; $display("FAIL mid_rehold_e%0d: got %0b want %0b", i + 1, ready_w, exp_rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_back_to_back();
    test_drain_latency();
    test_wrap();
    test_mailbox();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
